// File: rtl/ext_alu_sequencer_pkg.sv
// ext_alu_sequencer_pkg
//   Shared constants for the external ALU handshake: data/opcode/CSR widths,
//   opcode values, CSR bit positions and the sequencer state encoding.
package ext_alu_sequencer_pkg;

    localparam int ALU_DATA_BITS    = 32;
    localparam int ALU_OP_BITS      = 2;
    localparam int ALU_CSR_IN_BITS  = 3;
    localparam int ALU_CSR_OUT_BITS = 3;

    localparam logic [ALU_OP_BITS-1:0] ALUOP_DIV = 2'd1;
    localparam logic [ALU_OP_BITS-1:0] ALUOP_MUL = 2'd2;

    // CSR_ALU_IN bit positions (sequencer -> unit)
    localparam int CSR_IN_Z_ACK = 0;
    localparam int CSR_IN_A_STB = 1;
    localparam int CSR_IN_B_STB = 2;

    // CSR_ALU_OUT bit positions (unit -> sequencer)
    localparam int CSR_OUT_A_ACK = 0;
    localparam int CSR_OUT_B_ACK = 1;
    localparam int CSR_OUT_Z_STB = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_A = 3'd1,
        ST_SEND_B = 3'd2,
        ST_WAIT_Z = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/ext_alu_watchdog.sv
// ext_alu_watchdog
//   Per-phase cycle counter. Counts while enable is high, restarts on clear,
//   saturates at TMO_CYC-1 and flags expired while sitting there.
// Ports:
//   clk, rst  clock / async active-low reset
//   clear     restart count (phase change)
//   enable    a wait phase is active
//   expired   phase has used its full cycle budget
module ext_alu_watchdog #(
    parameter int TMO_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(TMO_CYC - 1);

    logic [TW-1:0] timer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            timer <= '0;
        else if (clear)
            timer <= '0;
        else if (enable && timer != LAST)
            timer <= timer + 1'b1;
    end

    assign expired = enable && (timer == LAST);

endmodule

// File: rtl/ext_alu_sequencer.sv
// ext_alu_sequencer
//   Takes one op request from the core, walks the external ALU through its
//   get_a -> get_b -> put_z handshake and returns the result downstream.
//   A per-phase watchdog turns a hung unit into an error response and a
//   sticky hung flag that blocks further requests until reset.
// Ports:
//   clk, rst                     clock / async active-low reset
//   req_valid/ready/op/a/b       request port from the core
//   rsp_valid/ready/data/err     response port to the consumer
//   hung                         sticky timeout indicator
//   OP1, OP2, ALUOP              operand/opcode latches to the ALU
//   CSR_ALU_IN                   {b_stb, a_stb, z_ack} to the ALU
//   CSR_ALU_OUT                  {z_stb, b_ack, a_ack} from the ALU
//   OP3                          result from the ALU
module ext_alu_sequencer
    import ext_alu_sequencer_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_BITS,
    parameter int OP_W    = ALU_OP_BITS,
    parameter int TMO_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              hung,
    output logic [DATA_W-1:0] OP1,
    output logic [DATA_W-1:0] OP2,
    output logic [OP_W-1:0]   ALUOP,
    output logic [2:0]        CSR_ALU_IN,
    input  logic [2:0]        CSR_ALU_OUT,
    input  logic [DATA_W-1:0] OP3
);

    state_t state, state_nxt;
    logic   ld_ops, ld_ok, ld_err, set_hung;
    logic   wd_en, wd_exp;
    logic   op_legal;

    assign op_legal = (req_op == OP_W'(ALUOP_DIV)) || (req_op == OP_W'(ALUOP_MUL));
    assign wd_en    = (state == ST_SEND_A) || (state == ST_SEND_B) || (state == ST_WAIT_Z);

    ext_alu_watchdog #(.TMO_CYC(TMO_CYC)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_nxt != state),
        .enable  (wd_en),
        .expired (wd_exp)
    );

    // Next state and register load strobes. In each wait phase the awaited
    // bit is tested before the watchdog so an ack on the last cycle wins.
    always_comb begin
        state_nxt = state;
        ld_ops    = 1'b0;
        ld_ok     = 1'b0;
        ld_err    = 1'b0;
        set_hung  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && !hung) begin
                    if (op_legal) begin
                        ld_ops    = 1'b1;
                        state_nxt = ST_SEND_A;
                    end else begin
                        ld_err    = 1'b1;
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_SEND_A: begin
                if (CSR_ALU_OUT[CSR_OUT_A_ACK]) begin
                    state_nxt = ST_SEND_B;
                end else if (wd_exp) begin
                    ld_err    = 1'b1;
                    set_hung  = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_SEND_B: begin
                if (CSR_ALU_OUT[CSR_OUT_B_ACK]) begin
                    state_nxt = ST_WAIT_Z;
                end else if (wd_exp) begin
                    ld_err    = 1'b1;
                    set_hung  = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_WAIT_Z: begin
                if (CSR_ALU_OUT[CSR_OUT_Z_STB]) begin
                    ld_ok     = 1'b1;
                    state_nxt = ST_RESP;
                end else if (wd_exp) begin
                    ld_err    = 1'b1;
                    set_hung  = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand latches hold after the transaction so the wrapper's result
    // mux stays put while the unit drops z_stb.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            OP1      <= '0;
            OP2      <= '0;
            ALUOP    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            hung     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld_ops) begin
                OP1   <= req_a;
                OP2   <= req_b;
                ALUOP <= req_op;
            end
            if (ld_ok) begin
                rsp_data <= OP3;
                rsp_err  <= 1'b0;
            end
            if (ld_err) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
            if (set_hung)
                hung <= 1'b1;
        end
    end

    assign req_ready = (state == ST_IDLE) && !hung;
    assign rsp_valid = (state == ST_RESP);

    always_comb begin
        CSR_ALU_IN = 3'b000;
        case (state)
            ST_SEND_A: CSR_ALU_IN[CSR_IN_A_STB] = 1'b1;
            ST_SEND_B: CSR_ALU_IN[CSR_IN_B_STB] = 1'b1;
            ST_WAIT_Z: CSR_ALU_IN[CSR_IN_Z_ACK] = 1'b1;
            default:   CSR_ALU_IN = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_ext_alu_sequencer.sv
// tb_ext_alu_sequencer
//   Drives requests against a behavioural ALU stub with programmable ack
//   delays and compares every response, latency and CSR code against a
//   phase-level model of the handshake.
module tb_ext_alu_sequencer;
    localparam int TMO = 8;
    localparam int HANG = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        hung;
    logic [31:0] OP1, OP2;
    logic [1:0]  ALUOP;
    logic [2:0]  CSR_ALU_IN;
    logic [2:0]  CSR_ALU_OUT = '0;
    logic [31:0] OP3 = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // model state carried between transactions
    logic [1:0]  m_aluop = '0;
    logic [31:0] m_op1 = '0, m_op2 = '0;

    always #5 clk = ~clk;

    ext_alu_sequencer #(.DATA_W(32), .OP_W(2), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .hung(hung),
        .OP1(OP1), .OP2(OP2), .ALUOP(ALUOP),
        .CSR_ALU_IN(CSR_ALU_IN), .CSR_ALU_OUT(CSR_ALU_OUT), .OP3(OP3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 2'd2) return a * b;
        if (op == 2'd1) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        return 32'hDEAD_BEEF;
    endfunction

    task automatic rst_chk(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_hung"}, hung, 0);
        chk({tag, "_csr_in"}, CSR_ALU_IN, 0);
        chk({tag, "_op1"}, OP1, 0);
        chk({tag, "_op2"}, OP2, 0);
        chk({tag, "_aluop"}, ALUOP, 0);
        m_aluop = '0; m_op1 = '0; m_op2 = '0;
    endtask

    // Pulse reset between clock edges; called just after a negedge.
    task automatic rst_pulse(input string tag);
        #1 rst = 1'b0;
        CSR_ALU_OUT = '0;
        #1 rst_chk(tag);
        #1 rst = 1'b1;
    endtask

    // One request. da/db/dz are cycles the stub waits in each phase before
    // acking; any value >= TMO means the watchdog fires first.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int da, input int db, input int dz, input int rdly, input bit abort_b);
        bit legal, to, done;
        int ph[3];
        int lat, cyc, cnt;
        logic [2:0] prev, exp_code;
        logic [31:0] exp_data;

        legal = (op == 2'd1) || (op == 2'd2);
        ph[0] = da; ph[1] = db; ph[2] = dz;
        lat = 0; to = 0;
        if (legal) begin
            for (int i = 0; i < 3; i++) begin
                if (ph[i] <= TMO - 1) lat += ph[i] + 1;
                else begin lat += TMO; to = 1; break; end
            end
        end
        exp_data = (!legal || to) ? 32'h0 : alu_fn(op, a, b);

        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        if (legal) begin m_aluop = op; m_op1 = a; m_op2 = b; end

        prev = 3'b000; cnt = 0; cyc = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0; req_op = 2'($urandom); req_a = $urandom; req_b = $urandom;
            if (cyc > 100) begin
                chk("rsp_bound", 0, 1);
                return;
            end
            if (rsp_valid) begin
                done = 1;
            end else begin
                if (cyc <= ph[0] + 1) exp_code = 3'b010;
                else if (cyc <= ph[0] + ph[1] + 2) exp_code = 3'b100;
                else exp_code = 3'b001;
                chk("csr_in_phase", CSR_ALU_IN, exp_code);
                chk("aluop_stable", ALUOP, m_aluop);
                chk("req_ready_busy", req_ready, 0);
                if (CSR_ALU_IN != prev) cnt = 0; else cnt++;
                prev = CSR_ALU_IN;
                if (abort_b && CSR_ALU_IN == 3'b100) begin
                    rst_pulse("abort");
                    return;
                end
                CSR_ALU_OUT[0] = (CSR_ALU_IN == 3'b010) && (cnt >= da);
                CSR_ALU_OUT[1] = (CSR_ALU_IN == 3'b100) && (cnt >= db);
                CSR_ALU_OUT[2] = (CSR_ALU_IN == 3'b001) && (cnt >= dz);
                OP3 = alu_fn(ALUOP, OP1, OP2);
            end
        end

        chk("rsp_latency", cyc, lat + 1);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", rsp_err, (!legal || to));
        chk("hung", hung, to);
        chk("resp_aluop", ALUOP, m_aluop);
        chk("resp_op1", OP1, m_op1);
        chk("resp_op2", OP2, m_op2);
        chk("resp_csr_in", CSR_ALU_IN, 0);
        chk("resp_req_ready", req_ready, 0);
        // Unit outputs are ignored in RESP, so throw noise at them.
        CSR_ALU_OUT = 3'($urandom); OP3 = $urandom;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            CSR_ALU_OUT = 3'($urandom); OP3 = $urandom;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, exp_data);
            chk("bp_rsp_err", rsp_err, (!legal || to));
            chk("bp_req_ready", req_ready, 0);
            chk("bp_csr_in", CSR_ALU_IN, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        CSR_ALU_OUT = '0;
        @(negedge clk);
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, !to);
        if (to) rst_pulse("hung_rst");
    endtask

    initial begin
        int r, d[3];
        logic [1:0] op;
        #2 rst_chk("reset");
        #10 rst = 1'b1;

        // directed
        run_txn(2'd2, 32'h4000_0000, 32'h4040_0000, 0, 0, 0, 0, 0);
        run_txn(2'd1, 32'h4120_0000, 32'h4000_0000, 1, 2, 3, 1, 0);
        run_txn(2'd3, 32'd5, 32'd7, 0, 0, 0, 0, 0);
        run_txn(2'd0, 32'd9, 32'd9, 0, 0, 0, 2, 0);
        run_txn(2'd2, 32'd12345, 32'd678, TMO-1, TMO-1, TMO-1, 0, 0);
        run_txn(2'd2, 32'h0001_0001, 32'h0000_0003, 0, 0, 2, 20, 0);
        run_txn(2'd2, 32'd3, 32'd4, 0, 0, HANG, 3, 0);
        run_txn(2'd1, 32'd100, 32'd7, TMO, 0, 0, 0, 0);
        run_txn(2'd1, 32'd100, 32'd7, 0, TMO + 2, 0, 1, 0);
        run_txn(2'd2, 32'hAAAA_5555, 32'h1234_5678, 0, 1, 0, 0, 1);
        run_txn(2'd2, 32'h4000_0000, 32'h4040_0000, 0, 0, 0, 0, 0);

        // random
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 8) ? 2'($urandom_range(1, 2)) : 2'($urandom);
            for (int k = 0; k < 3; k++) begin
                r = $urandom_range(0, 19);
                d[k] = (r < 16) ? $urandom_range(0, 4) : (r < 18) ? TMO - 1 : $urandom_range(TMO, TMO + 3);
            end
            run_txn(op, $urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
                    d[0], d[1], d[2], $urandom_range(0, 3), ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #500000;
        $display("FAIL global_timeout: sim time %0t exceeded bound", $time);
        $fatal(1, "timeout");
    end

endmodule
